// File: rtl/dccm.sv
`default_nettype none
// ============================================================================
// Module   : dccm
// Purpose  : Data closely-coupled memory for the LSU. Clears every word after
//            reset, then serves one read and one write per cycle with
//            1-cycle read latency and write-first same-index forwarding.
// Option   : DCCM_PARITY_EN - stores an even-parity bit per word, supports
//            parity-error injection on writes, flags mismatches on reads.
// Revision : 1.0 - initial release
// ============================================================================
module dccm #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  input  logic            dccm_par_inj,
  output logic            dccm_init_done,
  output logic            dccm_par_err
);

`ifdef DCCM_PARITY_EN
  localparam int MW = XLEN + 1;
`else
  localparam int MW = XLEN;
`endif

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;

  logic [MW-1:0]   mem [DEPTH];

  logic [AW-1:0]   ridx;
  logic [AW-1:0]   widx;
  logic            fwd;
  logic [MW-1:0]   rd_word;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [MW-1:0]   mem_wword;

  // Word indices: byte offset dropped, upper bits truncated so addresses alias.
  assign ridx    = lsu_dccm_raddr[AW+1:2];
  assign widx    = lsu_dccm_waddr[AW+1:2];
  assign fwd     = lsu_dccm_wen && (widx == ridx);
  assign rd_word = mem[ridx];

  // Array write port: clearing writes during INIT, LSU stores once READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wword = '0;
    if (state == ST_INIT) begin
      // All-zero data has even parity 0, so an all-zero word is correct.
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wword = '0;
    end else begin
      mem_we    = lsu_dccm_wen;
      mem_waddr = widx;
`ifdef DCCM_PARITY_EN
      mem_wword = {(^lsu_dccm_wdata) ^ dccm_par_inj, lsu_dccm_wdata};
`else
      mem_wword = lsu_dccm_wdata;
`endif
    end
  end

  // Storage array; deliberately not reset, INIT clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Init sequencer: walks the clear counter once, then parks in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_INIT;
      clr_cnt        <= '0;
      dccm_init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state          <= ST_READY;
            dccm_init_done <= 1'b1;
          end
        end
        ST_READY: begin
          state          <= ST_READY;
          dccm_init_done <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Read port: registered data held between reads, valid pulses per read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_dccm_rdata      <= '0;
      lsu_dccm_rvalid_out <= 1'b0;
    end else begin
      lsu_dccm_rvalid_out <= 1'b0;
      if (state == ST_READY && lsu_dccm_rvalid_in) begin
        lsu_dccm_rvalid_out <= 1'b1;
        lsu_dccm_rdata      <= fwd ? lsu_dccm_wdata : rd_word[XLEN-1:0];
      end
    end
  end

`ifdef DCCM_PARITY_EN
  // Parity check on array reads; forwarded data bypasses the array so never errs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dccm_par_err <= 1'b0;
    end else begin
      dccm_par_err <= (state == ST_READY) && lsu_dccm_rvalid_in && !fwd && (^rd_word);
    end
  end

  logic unused_lo;
  assign unused_lo = ^{lsu_dccm_raddr[1:0], lsu_dccm_waddr[1:0]};
`else
  assign dccm_par_err = 1'b0;

  logic unused_lo;
  assign unused_lo = ^{lsu_dccm_raddr[1:0], lsu_dccm_waddr[1:0], dccm_par_inj};
`endif

  generate
    if (AW + 2 < XLEN) begin : g_addr_hi
      logic unused_hi;
      assign unused_hi = ^{lsu_dccm_raddr[XLEN-1:AW+2], lsu_dccm_waddr[XLEN-1:AW+2]};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dccm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dccm
// Purpose  : Directed self-checking bench for dccm with DEPTH=16. Parity
//            checks adapt to DCCM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dccm;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] raddr;
  logic            rvalid_in;
  logic [XLEN-1:0] rdata;
  logic            rvalid_out;
  logic [XLEN-1:0] waddr;
  logic            wen;
  logic [XLEN-1:0] wdata;
  logic            par_inj;
  logic            init_done;
  logic            par_err;

  int n_tests;
  int n_fail;

  dccm #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_dccm_raddr      (raddr),
    .lsu_dccm_rvalid_in  (rvalid_in),
    .lsu_dccm_rdata      (rdata),
    .lsu_dccm_rvalid_out (rvalid_out),
    .lsu_dccm_waddr      (waddr),
    .lsu_dccm_wen        (wen),
    .lsu_dccm_wdata      (wdata),
    .dccm_par_inj        (par_inj),
    .dccm_init_done      (init_done),
    .dccm_par_err        (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rvalid_in = 1'b0;
    wen       = 1'b0;
    par_inj   = 1'b0;
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
  endtask

  task automatic rd(input logic [31:0] a);
    rvalid_in = 1'b1;
    raddr     = a;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic inj);
    wen     = 1'b1;
    waddr   = a;
    wdata   = d;
    par_inj = inj;
  endtask

  // Checks the read result of the previous cycle's read.
  task automatic expect_read(input string tag, input logic [31:0] d, input logic perr);
    check({tag, "_rvalid"}, {31'd0, rvalid_out}, 32'd1);
    check({tag, "_rdata"}, rdata, d);
`ifdef DCCM_PARITY_EN
    check({tag, "_parerr"}, {31'd0, par_err}, {31'd0, perr});
`else
    check({tag, "_parerr"}, {31'd0, par_err}, 32'd0);
`endif
  endtask

  // Releases reset at the start of cycle 0 and checks init_done through cycle DEPTH.
  task automatic run_init(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      check($sformatf("%s_done_c%0d", tag, c), {31'd0, init_done}, 32'd0);
      tick();
    end
    check($sformatf("%s_done_c%0d", tag, DEPTH), {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid_out}, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    check("rst_parerr", {31'd0, par_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- INIT with requests injected in cycle 2 ----
    for (int c = 0; c < DEPTH; c++) begin
      check($sformatf("init_done_c%0d", c), {31'd0, init_done}, 32'd0);
      if (c == 3) check("init_rd_dropped", {31'd0, rvalid_out}, 32'd0);
      if (c == 2) begin
        wr(32'h8, 32'h12345678, 1'b0);
        rd(32'h8);
      end else begin
        idle();
      end
      tick();
    end
    idle();
    check("init_done_c16", {31'd0, init_done}, 32'd1);
    tick();

    // Cycle 17: read 0x3C -> zero in cycle 18.
    rd(32'h3C);
    tick();
    idle();
    expect_read("cleared_3c", 32'h0, 1'b0);
    rd(32'h8);
    tick();
    idle();
    expect_read("init_wr_dropped", 32'h0, 1'b0);
    tick();
    check("rvalid_drop", {31'd0, rvalid_out}, 32'd0);

    // ---- write then read ----
    wr(32'h10, 32'hDEADBEEF, 1'b0);
    tick();
    idle();
    rd(32'h12);
    tick();
    idle();
    expect_read("wr_then_rd", 32'hDEADBEEF, 1'b0);
    tick();
    check("wr_rd_rvalid_low", {31'd0, rvalid_out}, 32'd0);
    check("wr_rd_hold", rdata, 32'hDEADBEEF);

    // ---- forwarding ----
    wr(32'h24, 32'h0BADF00D, 1'b0);
    tick();
    idle();
    wr(32'h20, 32'hA5A5A5A5, 1'b1);
    rd(32'h20);
    tick();
    idle();
    expect_read("fwd_same", 32'hA5A5A5A5, 1'b0);
    wr(32'h20, 32'h5A5A5A5A, 1'b0);
    rd(32'h24);
    tick();
    idle();
    expect_read("fwd_diff_old", 32'h0BADF00D, 1'b0);

    // ---- back-to-back reads, last write wins ----
    rd(32'h20);
    tick();
    expect_read("b2b_0", 32'h5A5A5A5A, 1'b0);
    rd(32'h10);
    tick();
    expect_read("b2b_1", 32'hDEADBEEF, 1'b0);
    rd(32'h27);
    tick();
    idle();
    expect_read("b2b_2", 32'h0BADF00D, 1'b0);

    // ---- aliasing ----
    wr(32'h40, 32'h11, 1'b0);
    tick();
    idle();
    rd(32'h0);
    tick();
    idle();
    expect_read("alias_0", 32'h11, 1'b0);

    // ---- parity injection on a stored word ----
    wr(32'h4, 32'h1, 1'b1);
    tick();
    idle();
    rd(32'h4);
    tick();
    idle();
    expect_read("par_inj", 32'h1, 1'b1);
    wr(32'h4, 32'h3, 1'b0);
    tick();
    idle();
    rd(32'h4);
    tick();
    idle();
    expect_read("par_clean", 32'h3, 1'b0);

    // ---- reset in READY with a valid read pending on the outputs ----
    rd(32'h10);
    tick();
    idle();
    check("pre_rst_rvalid", {31'd0, rvalid_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_rdata", rdata, 32'd0);
    check("arst_rvalid", {31'd0, rvalid_out}, 32'd0);
    check("arst_done", {31'd0, init_done}, 32'd0);

    // ---- reset in INIT cycle 5 ----
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midinit_done", {31'd0, init_done}, 32'd0);
    check("midinit_rvalid", {31'd0, rvalid_out}, 32'd0);
    run_init("reinit");
    tick();
    rd(32'h10);
    tick();
    idle();
    expect_read("reinit_cleared", 32'h0, 1'b0);
    rd(32'h0);
    tick();
    idle();
    expect_read("reinit_cleared0", 32'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
